// File: rtl/conv2_maxpool_relu_pkg.sv
// Shared constants and the ReLU-with-saturation helper for the conv2 pooling stage.
package conv2_maxpool_relu_pkg;

  localparam int CONV2_OUT_W = 8;
  localparam int CONV2_OUT_H = 8;
  localparam int CONV2_BIT   = 14;
  localparam int POOL2_BIT   = 12;

  // Negative -> 0, otherwise clamp to the largest positive value of an out_bit signed word.
  function automatic logic [31:0] relu_sat(input logic signed [31:0] x,
                                           input int unsigned        out_bit);
    logic signed [31:0] lim;
    lim = (32'sd1 <<< (out_bit - 1)) - 32'sd1;
    if (x < 0) begin
      return '0;
    end else if (x > lim) begin
      return lim;
    end else begin
      return x;
    end
  endfunction

endpackage

// File: rtl/conv2_maxpool_relu_pool2_channel.sv
// One channel of the 2x2 stride-2 max pool: activation, horizontal pair max,
// half-row buffer for the even row, and the registered pooled output.
module pool2_channel
  import conv2_maxpool_relu_pkg::*;
#(
  parameter int WIDTH   = CONV2_OUT_W,
  parameter int IN_BIT  = CONV2_BIT,
  parameter int OUT_BIT = POOL2_BIT,
  localparam int CW     = $clog2(WIDTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      valid_i,
  input  logic [CW-1:0]             col_i,
  input  logic                      row_odd_i,
  input  logic signed [IN_BIT-1:0]  in_i,
  output logic signed [OUT_BIT-1:0] pool_o
);

  localparam int HALF = WIDTH / 2;

  logic signed [31:0]        x_ext;
  logic signed [OUT_BIT-1:0] act;
  logic signed [OUT_BIT-1:0] pair_q;
  logic signed [OUT_BIT-1:0] h_max;
  logic signed [OUT_BIT-1:0] buf_rd;
  logic signed [OUT_BIT-1:0] pool_d;
  logic signed [OUT_BIT-1:0] pool_q;
  logic signed [OUT_BIT-1:0] buf_q [HALF];
  logic [CW-2:0]             slot;

  assign x_ext  = 32'(in_i);
  assign act    = OUT_BIT'(relu_sat(x_ext, OUT_BIT));
  assign slot   = col_i[CW-1:1];
  assign h_max  = (act > pair_q) ? act : pair_q;
  assign buf_rd = buf_q[slot];
  assign pool_d = (buf_rd > h_max) ? buf_rd : h_max;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pair_q <= '0;
      pool_q <= '0;
      for (int i = 0; i < HALF; i++) begin
        buf_q[i] <= '0;
      end
    end else if (valid_i) begin
      if (!col_i[0]) begin
        pair_q <= act;
      end else if (!row_odd_i) begin
        buf_q[slot] <= h_max;
      end else begin
        pool_q <= pool_d;
      end
    end
  end

  assign pool_o = pool_q;

endmodule

// File: rtl/conv2_maxpool_relu.sv
// Post-conv2 stage: three lock-step channels of ReLU + saturation + 2x2 max pool,
// sharing one raster position counter and one output-valid pulse.
module conv2_maxpool_relu
  import conv2_maxpool_relu_pkg::*;
#(
  parameter int WIDTH   = CONV2_OUT_W,
  parameter int HEIGHT  = CONV2_OUT_H,
  parameter int IN_BIT  = CONV2_BIT,
  parameter int OUT_BIT = POOL2_BIT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      valid_in,
  input  logic signed [IN_BIT-1:0]  conv_in_1,
  input  logic signed [IN_BIT-1:0]  conv_in_2,
  input  logic signed [IN_BIT-1:0]  conv_in_3,
  output logic signed [OUT_BIT-1:0] pool_out_1,
  output logic signed [OUT_BIT-1:0] pool_out_2,
  output logic signed [OUT_BIT-1:0] pool_out_3,
  output logic                      valid_out_pool
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);

  // Valid-only stream: valid_in qualifies one pixel on every channel, there is
  // no ready; valid_out_pool is a single-cycle pulse the consumer must take.
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          valid_q, valid_d;

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    valid_d = 1'b0;
    if (valid_in) begin
      valid_d = col_q[0] & row_q[0];
      if (col_q == CW'(WIDTH - 1)) begin
        col_d = '0;
        row_d = (row_q == RW'(HEIGHT - 1)) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
    end
  end

  assign valid_out_pool = valid_q;

  pool2_channel #(.WIDTH(WIDTH), .IN_BIT(IN_BIT), .OUT_BIT(OUT_BIT)) u_ch1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_i   (valid_in),
    .col_i     (col_q),
    .row_odd_i (row_q[0]),
    .in_i      (conv_in_1),
    .pool_o    (pool_out_1)
  );

  pool2_channel #(.WIDTH(WIDTH), .IN_BIT(IN_BIT), .OUT_BIT(OUT_BIT)) u_ch2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_i   (valid_in),
    .col_i     (col_q),
    .row_odd_i (row_q[0]),
    .in_i      (conv_in_2),
    .pool_o    (pool_out_2)
  );

  pool2_channel #(.WIDTH(WIDTH), .IN_BIT(IN_BIT), .OUT_BIT(OUT_BIT)) u_ch3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_i   (valid_in),
    .col_i     (col_q),
    .row_odd_i (row_q[0]),
    .in_i      (conv_in_3),
    .pool_o    (pool_out_3)
  );

endmodule

// File: tb/tb_conv2_maxpool_relu.sv
// Directed bench for conv2_maxpool_relu: six frame-level scenarios with
// hand-derived per-window expectations, checked by immediate assertions.
module tb_conv2_maxpool_relu;

  logic               clk;
  logic               rst_n;
  logic               valid_in;
  logic signed [13:0] conv_in_1, conv_in_2, conv_in_3;
  logic signed [11:0] pool_out_1, pool_out_2, pool_out_3;
  logic               valid_out_pool;

  int n_checks;
  int n_fail;
  int pulse_cnt;
  int last_exp [3];

  conv2_maxpool_relu dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .valid_in       (valid_in),
    .conv_in_1      (conv_in_1),
    .conv_in_2      (conv_in_2),
    .conv_in_3      (conv_in_3),
    .pool_out_1     (pool_out_1),
    .pool_out_2     (pool_out_2),
    .pool_out_3     (pool_out_3),
    .valid_out_pool (valid_out_pool)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid_out_pool) pulse_cnt++;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Stimulus pattern per scenario, pixel (r,c) on channel ch (1..3).
  function automatic int in_val(input int scn, input int ch, input int r, input int c);
    int p;
    p = r * 8 + c;
    case (scn)
      1: return p;
      2: return -100;
      3: return (r == 2 && c == 3) ? 5000 : 1;
      4: return (ch == 1) ? p : (ch == 2) ? -p : 7;
      default: return 0;
    endcase
  endfunction

  // Hand-derived pooled value for window (wr,wc).
  function automatic int exp_val(input int scn, input int ch, input int wr, input int wc);
    case (scn)
      1: return (2 * wr + 1) * 8 + 2 * wc + 1;
      2: return 0;
      3: return (wr == 1 && wc == 1) ? 2047 : 1;
      4: return (ch == 1) ? (2 * wr + 1) * 8 + 2 * wc + 1 : (ch == 2) ? 0 : 7;
      default: return 0;
    endcase
  endfunction

  function automatic int out_ch(input int ch);
    case (ch)
      1: return int'(pool_out_1);
      2: return int'(pool_out_2);
      default: return int'(pool_out_3);
    endcase
  endfunction

  // driver: called at posedge+1; drives one pixel, then checks right after the sampling edge
  task automatic drive_pixel(input int scn, input int r, input int c);
    bit pulse;
    conv_in_1 = 14'(in_val(scn, 1, r, c));
    conv_in_2 = 14'(in_val(scn, 2, r, c));
    conv_in_3 = 14'(in_val(scn, 3, r, c));
    valid_in  = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    pulse = (r % 2 == 1) && (c % 2 == 1);
    check($sformatf("s%0d_valid_r%0d_c%0d", scn, r, c), int'(valid_out_pool), int'(pulse));
    if (pulse) begin
      for (int ch = 1; ch <= 3; ch++) begin
        last_exp[ch-1] = exp_val(scn, ch, r / 2, c / 2);
        check($sformatf("s%0d_ch%0d_win%0d_%0d", scn, ch, r / 2, c / 2), out_ch(ch), last_exp[ch-1]);
      end
    end
  endtask

  task automatic idle_cycles(input int scn, input int n);
    valid_in  = 1'b0;
    conv_in_1 = 14'sd1234;
    conv_in_2 = -14'sd77;
    conv_in_3 = 14'sd999;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("s%0d_gap_valid", scn), int'(valid_out_pool), 0);
      for (int ch = 1; ch <= 3; ch++) begin
        check($sformatf("s%0d_gap_hold_ch%0d", scn, ch), out_ch(ch), last_exp[ch-1]);
      end
    end
  endtask

  task automatic run_frame(input int scn, input int gap, input int npix);
    for (int p = 0; p < npix; p++) begin
      drive_pixel(scn, p / 8, p % 8);
      if (gap > 0) idle_cycles(scn, gap);
    end
  endtask

  task automatic check_pulses(input string tag, input int start, input int exp);
    @(negedge clk);
    #1;
    check(tag, pulse_cnt - start, exp);
  endtask

  initial begin
    int start;
    n_checks  = 0;
    n_fail    = 0;
    pulse_cnt = 0;
    for (int ch = 0; ch < 3; ch++) last_exp[ch] = 0;
    rst_n     = 1'b0;
    valid_in  = 1'b0;
    conv_in_1 = '0;
    conv_in_2 = '0;
    conv_in_3 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", int'(valid_out_pool), 0);
    check("reset_out1", int'(pool_out_1), 0);
    check("reset_out2", int'(pool_out_2), 0);
    check("reset_out3", int'(pool_out_3), 0);
    rst_n = 1'b1;

    // 1: ramp
    start = pulse_cnt;
    run_frame(1, 0, 64);
    check_pulses("s1_pulses", start, 16);

    // 2: all negative
    start = pulse_cnt;
    run_frame(2, 0, 64);
    check_pulses("s2_pulses", start, 16);

    // 3: one saturating spike
    start = pulse_cnt;
    run_frame(3, 0, 64);
    check_pulses("s3_pulses", start, 16);

    // 4: channel isolation
    start = pulse_cnt;
    run_frame(4, 0, 64);
    check_pulses("s4_pulses", start, 16);

    // 5: gaps after every input, then a back-to-back frame
    start = pulse_cnt;
    run_frame(1, 3, 64);
    run_frame(1, 0, 64);
    check_pulses("s5_pulses", start, 32);

    // 6: reset mid-frame after 20 inputs
    run_frame(1, 0, 20);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int ch = 0; ch < 3; ch++) last_exp[ch] = 0;
    check("s6_rst_valid", int'(valid_out_pool), 0);
    check("s6_rst_out1", int'(pool_out_1), 0);
    check("s6_rst_out2", int'(pool_out_2), 0);
    check("s6_rst_out3", int'(pool_out_3), 0);
    start = pulse_cnt;
    run_frame(1, 0, 64);
    check_pulses("s6_pulses", start, 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
